serdiv_rv: RTL
==============

# serdiv_rv

Parametrised sequential integer divider for the execute stage, succeeding the single-mode 1-bit/cycle divider. Adds RV64 word-mode operations (DIVW/DIVUW/REMW/REMUW), a selectable 1 or 2 quotient bits per cycle, full RISC-V special-case semantics and a same-cycle flush. Sits behind the issue stage as a multi-cycle functional unit with valid/ready on both sides.

## Interface
- WIDTH, 64: datapath width; 32 or 64.
- STEP, 1: quotient bits retired per DIVIDE cycle; 1 or 2.
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset (one clock; reset is synchronous and active-low).
- id_i  in  TRANS_ID_BITS  transaction id, captured on accept.
- op_a_i / op_b_i  in  WIDTH  dividend / divisor.
- opcode_i  in  2  0 udiv, 1 div, 2 urem, 3 rem.
- word_i  in  1  32-bit op on low halves, result sign-extended; ignored when WIDTH=32.
- in_vld_i  in  1  request valid.
- in_rdy_o  out  1  ready to accept.
- flush_i  in  1  abort current operation.
- out_vld_o  out  1  result valid.
- out_rdy_i  in  1  consumer ready.
- id_o  out  TRANS_ID_BITS  id of result.
- res_o  out  WIDTH  quotient or remainder.

## Operation
- Reset (rst_ni low at clk edge): state IDLE; in_rdy_o=1, out_vld_o=0, id_o=0, res_o=0.
- States: IDLE, DIVIDE, FINISH, DONE.
- IDLE: in_rdy_o=1. Accept when in_vld_i&in_rdy_o: capture id, opcode, word, signs; load |a|, |b| (word mode: low 32 bits, signed ops sign-extend bit 31 first).
- Normalisation on accept: La=lzc(|a|), Lb=lzc(|b|) over effective width EW (32 word, else WIDTH). If |b|>|a| (and b≠0): quotient 0, remainder a; N=0 -> FINISH. Else shift |b| left by Lb-La, N=ceil((Lb-La+1)/STEP) -> DIVIDE.
- DIVIDE: restoring step per quotient bit, STEP bits per cycle; counter decrements by 1; at 0 -> FINISH. For STEP=2 with odd bit count the first cycle retires one bit only.
- FINISH: apply sign: quotient negated if signed and sign(a)≠sign(b); remainder takes sign(a). Word mode: sign-extend bit 31 to WIDTH (also for udivw/uremw). Select quotient/remainder by opcode[1]. -> DONE.
- DONE: out_vld_o=1, res_o/id_o stable; on out_rdy_i -> IDLE.
- Special cases (RISC-V): b=0: quotient all-ones (EW bits, then sign-extended), remainder=a. Signed overflow (a=most-negative of EW, b=-1): quotient=a, remainder=0.
- flush_i: sampled every cycle, any state; next state IDLE, out_vld_o=0 and in_rdy_o=1 from next cycle; a request presented with flush_i high is not accepted (in_rdy_o forced 0 that cycle). Flush in DONE with out_rdy_i high: result dropped, not counted as delivered.

## Timing
- Accept in cycle T; first DIVIDE cycle T+1; out_vld_o first high at T+N+2.
- Trivial zero quotient (N=0): out_vld_o at T+2.
- Max N: EW/STEP (64-bit STEP=1: 64 -> out_vld at T+66; STEP=2: T+34).
- in_rdy_o low from T+1 until the cycle after the DONE handshake; no back-to-back accept in the handshake cycle.
- out_vld_o held with res_o/id_o constant until out_rdy_i; no combinational path in_vld_i->in_rdy_o or out_rdy_i->out_vld_o.

## Configuration
- SERDIV_FASTPATH_EN defined: b=0 and signed overflow bypass DIVIDE/FINISH; IDLE->DONE directly, out_vld_o at T+1 with the special-case result.
- Undefined: special cases run the normal path with N=EW/STEP (b=0 treated as Lb-La=EW-1 shift-free full iteration); results identical, latency T+EW/STEP+2.

## Test plan
- WIDTH=64, STEP=1, div a=-7 b=2 -> res=-3 (0xFFFF_FFFF_FFFF_FFFD); rem same operands -> -1; id echoed.
- udiv a=5 b=9 -> res=0, out_vld_o at T+2; urem -> 5.
- divw a=0x0000_0001_8000_0000 b=0xFFFF_FFFF_FFFF_FFFF -> res=0xFFFF_FFFF_8000_0000 (overflow); remw -> 0; with SERDIV_FASTPATH_EN out_vld_o at T+1.
- divu a=0x1234 b=0 -> res=0xFFFF_FFFF_FFFF_FFFF; remu -> 0x1234; divuw b=0 -> 0xFFFF_FFFF_FFFF_FFFF.
- STEP=2, udiv a=2^63 b=1 -> res=2^63, out_vld_o at T+34; hold out_rdy_i low 5 cycles -> res_o/out_vld_o stable.
- flush_i mid-DIVIDE and in DONE -> IDLE next cycle, out_vld_o=0, next request (udiv 100/7) -> 14 with new id; rst_ni low mid-DIVIDE -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/serdiv_rv.sv
// Sequential radix-2 restoring divider (1 or 2 quotient bits/cycle) with RV64 word ops.
// Define SERDIV_FASTPATH_EN to resolve divide-by-zero and signed overflow straight from IDLE.
module serdiv_rv #(
    parameter int unsigned WIDTH         = 64,
    parameter int unsigned STEP          = 1,
    parameter int unsigned TRANS_ID_BITS = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [TRANS_ID_BITS-1:0] id_i,
    input  logic [WIDTH-1:0]         op_a_i,
    input  logic [WIDTH-1:0]         op_b_i,
    input  logic [1:0]               opcode_i,
    input  logic                     word_i,
    input  logic                     in_vld_i,
    output logic                     in_rdy_o,
    input  logic                     flush_i,
    output logic                     out_vld_o,
    input  logic                     out_rdy_i,
    output logic [TRANS_ID_BITS-1:0] id_o,
    output logic [WIDTH-1:0]         res_o
);

`ifdef SERDIV_FASTPATH_EN
    localparam bit FAST_EN = 1'b1;
`else
    localparam bit FAST_EN = 1'b0;
`endif

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, DIVIDE, FINISH, DONE} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] r;
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] q;
    } dv_t;

    function automatic logic [WIDTH-1:0] ext32(input logic [WIDTH-1:0] v, input logic s);
        logic [WIDTH-1:0] r;
        r = v;
        for (int unsigned i = 32; i < WIDTH; i++) r[i] = s & v[31];
        return r;
    endfunction

    function automatic logic [CW-1:0] lzc(input logic [WIDTH-1:0] v);
        logic [CW-1:0] n;
        logic          found;
        n     = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (!found) begin
                if (v[WIDTH-1-i]) found = 1'b1;
                else              n = n + 1'b1;
            end
        end
        return n;
    endfunction

    function automatic dv_t rstep(input dv_t s);
        dv_t n;
        n = s;
        if (s.r >= s.d) begin
            n.r = s.r - s.d;
            n.q = {s.q[WIDTH-2:0], 1'b1};
        end else begin
            n.q = {s.q[WIDTH-2:0], 1'b0};
        end
        n.d = s.d >> 1;
        return n;
    endfunction

    // Divide-by-zero forces an all-ones quotient regardless of operand signs.
    function automatic logic [WIDTH-1:0] finish_res(
        input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] r,
        input logic neg, input logic sa, input logic dz, input logic rem, input logic w);
        logic [WIDTH-1:0] qf, rf, res;
        qf  = dz ? '1 : (neg ? '0 - q : q);
        rf  = sa ? '0 - r : r;
        res = rem ? rf : qf;
        if (w) res = ext32(res, 1'b1);
        return res;
    endfunction

    state_t                   state_q, state_n;
    dv_t                      dv_q, dv_n;
    logic [CW-1:0]            cnt_q, cnt_n;
    logic                     half_q, half_n;
    logic                     sign_a_q, sign_a_n;
    logic                     neg_q, neg_n;
    logic                     dz_q, dz_n;
    logic                     word_q, word_n;
    logic                     rem_q, rem_n;
    logic [TRANS_ID_BITS-1:0] id_q, id_n;
    logic [WIDTH-1:0]         res_q, res_n;

    logic                     word_eff, sg, sa, sb, bz, ovf;
    logic [WIDTH-1:0]         a_ext, b_ext, abs_a, abs_b, min_ext;
    logic [CW-1:0]            shift, bits, ncyc;

    assign in_rdy_o  = (state_q == IDLE) && !flush_i;
    assign out_vld_o = (state_q == DONE);
    assign id_o      = id_q;
    assign res_o     = res_q;

    always_comb begin
        word_eff = word_i && (WIDTH == 64);
        sg       = opcode_i[0];
        a_ext    = word_eff ? ext32(op_a_i, sg) : op_a_i;
        b_ext    = word_eff ? ext32(op_b_i, sg) : op_b_i;
        sa       = sg & a_ext[WIDTH-1];
        sb       = sg & b_ext[WIDTH-1];
        abs_a    = sa ? '0 - a_ext : a_ext;
        abs_b    = sb ? '0 - b_ext : b_ext;
        bz       = (b_ext == '0);
        min_ext  = '0;
        if (word_eff) begin
            min_ext[31] = 1'b1;
            min_ext     = ext32(min_ext, 1'b1);
        end else begin
            min_ext[WIDTH-1] = 1'b1;
        end
        ovf = sg && (a_ext == min_ext) && (b_ext == '1);
        // Divisor zero runs a full EW-bit pass with no alignment shift.
        if (bz) begin
            shift = '0;
            bits  = word_eff ? CW'(32) : CW'(WIDTH);
        end else begin
            shift = lzc(abs_b) - lzc(abs_a);
            bits  = shift + 1'b1;
        end
        ncyc = (STEP == 2) ? CW'((bits + 1'b1) >> 1) : bits;
    end

    always_comb begin
        state_n  = state_q;
        dv_n     = dv_q;
        cnt_n    = cnt_q;
        half_n   = half_q;
        sign_a_n = sign_a_q;
        neg_n    = neg_q;
        dz_n     = dz_q;
        word_n   = word_q;
        rem_n    = rem_q;
        id_n     = id_q;
        res_n    = res_q;
        case (state_q)
            IDLE: begin
                if (in_vld_i && in_rdy_o) begin
                    id_n     = id_i;
                    sign_a_n = sa;
                    neg_n    = sg & (sa ^ sb);
                    dz_n     = bz;
                    word_n   = word_eff;
                    rem_n    = opcode_i[1];
                    dv_n.r   = abs_a;
                    dv_n.d   = abs_b << shift;
                    dv_n.q   = '0;
                    cnt_n    = ncyc;
                    half_n   = (STEP == 2) && bits[0];
                    if (FAST_EN && (bz || ovf)) begin
                        res_n   = finish_res(abs_a, bz ? abs_a : '0, sg & (sa ^ sb), sa, bz,
                                             opcode_i[1], word_eff);
                        state_n = DONE;
                    end else if (!bz && (abs_b > abs_a)) begin
                        state_n = FINISH;
                    end else begin
                        state_n = DIVIDE;
                    end
                end
            end
            DIVIDE: begin
                dv_n = rstep(dv_q);
                if ((STEP == 2) && !half_q) dv_n = rstep(dv_n);
                half_n = 1'b0;
                cnt_n  = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) state_n = FINISH;
            end
            FINISH: begin
                res_n   = finish_res(dv_q.q, dv_q.r, neg_q, sign_a_q, dz_q, rem_q, word_q);
                state_n = DONE;
            end
            DONE: begin
                if (out_rdy_i) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (flush_i) state_n = IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            dv_q     <= '0;
            cnt_q    <= '0;
            half_q   <= 1'b0;
            sign_a_q <= 1'b0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            word_q   <= 1'b0;
            rem_q    <= 1'b0;
            id_q     <= '0;
            res_q    <= '0;
        end else begin
            state_q  <= state_n;
            dv_q     <= dv_n;
            cnt_q    <= cnt_n;
            half_q   <= half_n;
            sign_a_q <= sign_a_n;
            neg_q    <= neg_n;
            dz_q     <= dz_n;
            word_q   <= word_n;
            rem_q    <= rem_n;
            id_q     <= id_n;
            res_q    <= res_n;
        end
    end

endmodule
